// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction/data memory handshakes, ALU flag, datapath controls and status.
// master = control FSM side, slave = datapath/memory side.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
  logic [31:0]      instr;
  logic             imem_ready;
  logic             dmem_ready;
  logic             alu_zero;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             alu_src_b;
  logic [3:0]       alu_ctrl;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic [1:0]       err_code;

  modport master (
    input  instr, imem_ready, dmem_ready, alu_zero,
    output imem_req, ir_write, pc_write, pc_src, alu_src_b, alu_ctrl,
           mem_read, mem_write, mem_to_reg, reg_write, retired, halted, err_code
  );

  modport slave (
    output instr, imem_ready, dmem_ready, alu_zero,
    input  imem_req, ir_write, pc_write, pc_src, alu_src_b, alu_ctrl,
           mem_read, mem_write, mem_to_reg, reg_write, retired, halted, err_code
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32-subset control unit: fetch/decode/execute/memory/writeback sequencing,
// ALU control generation, retired-instruction counting and sticky error halt.
module multicycle_control_fsm #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_IMEM = 2'b10;
  localparam logic [1:0] ERR_DMEM = 2'b11;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, HALT
  } state_t;

  state_t            state_r;
  logic [6:0]        op_r;
  logic [2:0]        f3_r;
  logic [6:0]        f7_r;
  logic [WAIT_W-1:0] wait_r;
  logic [CNT_W-1:0]  retired_r;
  logic              halted_r;
  logic [1:0]        err_r;

  function automatic logic legal_instr(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
    logic ok;
    case (op)
      OP_R: begin
        case (f3)
          3'b000:         ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          3'b111, 3'b110: ok = (f7 == 7'b0000000);
          default:        ok = 1'b0;
        endcase
      end
      OP_I:               ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110);
      OP_LOAD, OP_STORE:  ok = (f3 == 3'b010);
      OP_BRANCH:          ok = (f3 == 3'b000) || (f3 == 3'b001);
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic state_t decode_target(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_R:              nxt = EXEC_R;
      OP_I:              nxt = EXEC_I;
      OP_LOAD, OP_STORE: nxt = MEM_ADDR;
      OP_BRANCH:         nxt = BRANCH;
      default:           nxt = HALT;
    endcase
    return nxt;
  endfunction

  // funct7[5] only selects SUB for register-register ops; addi ignores it.
  function automatic logic [3:0] arith_op(input logic is_r, input logic [2:0] f3,
                                          input logic [6:0] f7);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // State sequencing, IR latch, wait timer, retire counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= FETCH;
      op_r      <= 7'd0;
      f3_r      <= 3'd0;
      f7_r      <= 7'd0;
      wait_r    <= {WAIT_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
      halted_r  <= 1'b0;
      err_r     <= ERR_NONE;
    end else begin
      wait_r <= {WAIT_W{1'b0}};
      case (state_r)
        FETCH: begin
          if (bus.imem_ready) begin
            op_r    <= bus.instr[6:0];
            f3_r    <= bus.instr[14:12];
            f7_r    <= bus.instr[31:25];
            state_r <= DECODE;
          end else if (wait_r == WAIT_LAST) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
            err_r    <= ERR_IMEM;
          end else begin
            wait_r <= wait_r + WAIT_ONE;
          end
        end
        DECODE: begin
          if (legal_instr(op_r, f3_r, f7_r)) begin
            state_r <= decode_target(op_r);
          end else begin
            state_r  <= HALT;
            halted_r <= 1'b1;
            err_r    <= ERR_ILL;
          end
        end
        EXEC_R, EXEC_I: state_r <= WB_ALU;
        MEM_ADDR:       state_r <= (op_r == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD, MEM_WR: begin
          if (bus.dmem_ready) begin
            if (state_r == MEM_RD) begin
              state_r <= WB_MEM;
            end else begin
              state_r   <= FETCH;
              retired_r <= retired_r + CNT_ONE;
            end
          end else if (wait_r == WAIT_LAST) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
            err_r    <= ERR_DMEM;
          end else begin
            wait_r <= wait_r + WAIT_ONE;
          end
        end
        WB_ALU, WB_MEM, BRANCH: begin
          state_r   <= FETCH;
          retired_r <= retired_r + CNT_ONE;
        end
        HALT:    state_r <= HALT;
        default: begin
          state_r  <= HALT;
          halted_r <= 1'b1;
          err_r    <= ERR_ILL;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and latched opcode fields; all
  // outputs are forced low during the reset cycle so an abandoned instruction writes nothing.
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_b  = 1'b0;
    bus.alu_ctrl   = ALU_AND;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.retired    = {CNT_W{1'b0}};
    bus.halted     = 1'b0;
    bus.err_code   = ERR_NONE;
    if (reset) begin
      bus.imem_req = 1'b0;
    end else begin
      bus.retired  = retired_r;
      bus.halted   = halted_r;
      bus.err_code = err_r;
      case (state_r)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_write = bus.imem_ready;
          bus.pc_write = bus.imem_ready;
        end
        EXEC_R: begin
          bus.alu_ctrl = arith_op(1'b1, f3_r, f7_r);
        end
        EXEC_I: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = arith_op(1'b0, f3_r, f7_r);
        end
        MEM_ADDR: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = ALU_ADD;
        end
        MEM_RD: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = ALU_ADD;
          bus.mem_read  = 1'b1;
        end
        MEM_WR: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = ALU_ADD;
          bus.mem_write = 1'b1;
        end
        WB_ALU: bus.reg_write = 1'b1;
        WB_MEM: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        BRANCH: begin
          bus.alu_ctrl = ALU_SUB;
          bus.pc_src   = 1'b1;
          bus.pc_write = f3_r[0] ? ~bus.alu_zero : bus.alu_zero;
        end
        default: bus.imem_req = 1'b0;
      endcase
    end
  end
endmodule
